// File: rtl/rx_pkt_fifo_if.sv
// Purpose : 32-bit AXIS beat bundle used on both sides of rx_pkt_fifo.
// Signals : tdata  - beat data, byte 0 in [7:0]
//           tvldb  - valid bytes minus 1, meaningful on tlast beats
//           tvalid - beat valid
//           tready - sink ready
//           tlast  - last beat of frame
//           tuser  - bad-frame flag, meaningful on tlast beats
// Modports: master drives the beat, slave drives tready.
interface rx_pkt_fifo_if;
   logic [31:0] tdata;
   logic [1:0]  tvldb;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;

   modport master (output tdata, tvldb, tvalid, tlast, tuser, input tready);
   modport slave  (input tdata, tvldb, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/rx_pkt_fifo.sv
// Purpose : Store-and-forward receive packet FIFO. Whole frames are buffered;
//           only good frames that fit are forwarded, errored or oversized
//           frames are dropped in full. Good/dropped frame counters saturate.
// Ports   : clk_i         - receive user clock
//           rst_n_i       - asynchronous active-low reset
//           s_axis        - input stream (no backpressure, tready tied high)
//           m_axis        - output stream with backpressure (tuser tied low)
//           good_frames_o - committed frame count, saturating
//           drop_frames_o - dropped frame count, saturating
//
// Write-side states:
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_SYNC | after reset, discard beats until a tlast (frame boundary)
//   ST_PASS | write beats speculatively, commit on good tlast
//   ST_DROP | frame overflowed, discard until its tlast
module rx_pkt_fifo #(
   parameter int DEPTH_LOG2 = 9,
   parameter int CNT_W      = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   rx_pkt_fifo_if.slave     s_axis,
   rx_pkt_fifo_if.master    m_axis,
   output logic [CNT_W-1:0] good_frames_o,
   output logic [CNT_W-1:0] drop_frames_o
);

   localparam int AW    = DEPTH_LOG2;
   localparam int PW    = DEPTH_LOG2 + 1;
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t           r_state;
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_commit_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CNT_W-1:0] r_good_cnt;
   logic [CNT_W-1:0] r_drop_cnt;

   logic [34:0]      r_mem [DEPTH];
   logic [34:0]      r_rd_data;
   logic             r_rd_pend;
   logic [34:0]      r_out;
   logic             r_out_vld;
   logic [34:0]      r_skid;
   logic             r_skid_vld;

   logic             w_full;
   logic             w_wr_en;
   logic             w_pop;
   logic [1:0]       w_occ;
   logic             w_rd_en;

   assign s_axis.tready = 1'b1;

   // Occupancy uses rd_ptr before this edge's read increment.
   assign w_full  = (r_wr_ptr - r_rd_ptr) == FULL_CNT;
   assign w_wr_en = (r_state == ST_PASS) && s_axis.tvalid && !w_full &&
                    !(s_axis.tlast && s_axis.tuser);

   // Output stage holds at most two beats; the in-flight RAM read counts as
   // one so that it always has somewhere to land.
   assign w_pop   = r_out_vld && m_axis.tready;
   assign w_occ   = {1'b0, r_out_vld} + {1'b0, r_skid_vld} + {1'b0, r_rd_pend};
   assign w_rd_en = (r_rd_ptr != r_commit_ptr) && ((w_occ - {1'b0, w_pop}) < 2'd2);

   always_ff @(posedge clk_i) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr[AW-1:0]] <= {s_axis.tlast, s_axis.tvldb, s_axis.tdata};
      end
      if (w_rd_en) begin
         r_rd_data <= r_mem[r_rd_ptr[AW-1:0]];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= ST_SYNC;
         r_wr_ptr     <= '0;
         r_commit_ptr <= '0;
         r_good_cnt   <= '0;
         r_drop_cnt   <= '0;
      end else begin
         case (r_state)
            ST_SYNC: begin
               if (s_axis.tvalid && s_axis.tlast) begin
                  r_state <= ST_PASS;
               end
            end
            ST_PASS: begin
               if (s_axis.tvalid) begin
                  if (w_full) begin
                     r_wr_ptr <= r_commit_ptr;
                     if (s_axis.tlast) begin
                        if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                     end else begin
                        r_state <= ST_DROP;
                     end
                  end else if (s_axis.tlast && s_axis.tuser) begin
                     r_wr_ptr <= r_commit_ptr;
                     if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                  end else begin
                     r_wr_ptr <= r_wr_ptr + PW'(1);
                     if (s_axis.tlast) begin
                        r_commit_ptr <= r_wr_ptr + PW'(1);
                        if (~&r_good_cnt) r_good_cnt <= r_good_cnt + CNT_W'(1);
                     end
                  end
               end
            end
            ST_DROP: begin
               if (s_axis.tvalid && s_axis.tlast) begin
                  if (~&r_drop_cnt) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                  r_state <= ST_PASS;
               end
            end
            default: r_state <= ST_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_rd_ptr   <= '0;
         r_rd_pend  <= 1'b0;
         r_out      <= '0;
         r_out_vld  <= 1'b0;
         r_skid     <= '0;
         r_skid_vld <= 1'b0;
      end else begin
         r_rd_pend <= w_rd_en;
         if (w_rd_en) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         if (w_pop || !r_out_vld) begin
            // Skid beat is older than the one arriving from RAM.
            if (r_skid_vld) begin
               r_out      <= r_skid;
               r_out_vld  <= 1'b1;
               r_skid_vld <= r_rd_pend;
               if (r_rd_pend) r_skid <= r_rd_data;
            end else if (r_rd_pend) begin
               r_out     <= r_rd_data;
               r_out_vld <= 1'b1;
            end else begin
               r_out_vld <= 1'b0;
            end
         end else if (r_rd_pend) begin
            r_skid     <= r_rd_data;
            r_skid_vld <= 1'b1;
         end
      end
   end

   assign m_axis.tdata  = r_out[31:0];
   assign m_axis.tvldb  = r_out[33:32];
   assign m_axis.tlast  = r_out[34];
   assign m_axis.tvalid = r_out_vld;
   assign m_axis.tuser  = 1'b0;

   assign good_frames_o = r_good_cnt;
   assign drop_frames_o = r_drop_cnt;

endmodule

// File: tb/tb_rx_pkt_fifo.sv
module tb_rx_pkt_fifo;
   localparam int DLOG  = 4;
   localparam int DEPTH = 1 << DLOG;

   logic        clk_i   = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        ready   = 1'b0;
   logic [15:0] good, drop;
   logic [1:0]  good2, drop2;

   int checks = 0;
   int errors = 0;

   int rdy_mode = 0;
   bit rdy_fix  = 1'b1;
   int pat_cnt  = 0;

   // Reference model state: expected output beats and frame counts
   logic [34:0] exp_q[$];
   int          mdl_good = 0;
   int          mdl_drop = 0;
   bit          mdl_sync = 1'b0;
   int          mdl_used = 0;

   rx_pkt_fifo_if s_if ();
   rx_pkt_fifo_if m_if ();
   rx_pkt_fifo_if s2_if ();
   rx_pkt_fifo_if m2_if ();

   assign m_if.tready  = ready;
   assign m2_if.tready = ready;

   rx_pkt_fifo #(.DEPTH_LOG2(DLOG), .CNT_W(16)) dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .s_axis        (s_if),
      .m_axis        (m_if),
      .good_frames_o (good),
      .drop_frames_o (drop)
   );

   rx_pkt_fifo #(.DEPTH_LOG2(DLOG), .CNT_W(2)) dut_sat (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .s_axis        (s2_if),
      .m_axis        (m2_if),
      .good_frames_o (good2),
      .drop_frames_o (drop2)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #900000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1);
   end

   // Downstream ready generator: fixed, random, or 1,0,0 repeating
   initial forever begin
      @(posedge clk_i);
      #1;
      case (rdy_mode)
         1:       ready = 1'($urandom_range(0, 1));
         2:       begin ready = (pat_cnt % 3 == 0); pat_cnt++; end
         default: ready = rdy_fix;
      endcase
   end

   // Monitor: pops expected beats on each transfer, checks hold during stalls
   logic [34:0] mon_act, mon_cmp, mon_exp, prev_beat;
   bit          stall_prev = 1'b0;
   always @(negedge clk_i) begin
      if (!rst_n_i) begin
         stall_prev = 1'b0;
      end else begin
         mon_act = {m_if.tlast, m_if.tvldb, m_if.tdata};
         if (stall_prev) begin
            checks++;
            if (!m_if.tvalid || mon_act != prev_beat) begin
               errors++;
               $display("FAIL hold: got valid=%0b beat=%h required valid=1 beat=%h",
                        m_if.tvalid, mon_act, prev_beat);
            end
         end
         if (m_if.tvalid && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL beat_extra: got %h required no beat", mon_act);
            end else begin
               mon_exp = exp_q.pop_front();
               mon_cmp = mon_act;
               if (!mon_exp[34]) begin
                  mon_exp[33:32] = 2'd0;
                  mon_cmp[33:32] = 2'd0;
               end
               if (mon_cmp != mon_exp) begin
                  errors++;
                  $display("FAIL beat: got %h required %h", mon_cmp, mon_exp);
               end
            end
         end
         stall_prev = m_if.tvalid && !ready;
         prev_beat  = mon_act;
      end
   end

   task automatic chk(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d required %0d", nm, act, req);
      end
   endtask

   function automatic int sat3(input int x);
      return (x > 3) ? 3 : x;
   endfunction

   task automatic chk_cnt(input string tag);
      chk({tag, "_good"},  int'(good),  mdl_good);
      chk({tag, "_drop"},  int'(drop),  mdl_drop);
      chk({tag, "_good2"}, int'(good2), sat3(mdl_good));
      chk({tag, "_drop2"}, int'(drop2), sat3(mdl_drop));
   endtask

   task automatic drive(input bit v, input logic [31:0] d, input logic [1:0] vb,
                        input bit l, input bit u);
      s_if.tvalid = v;   s2_if.tvalid = v;
      s_if.tdata  = d;   s2_if.tdata  = d;
      s_if.tvldb  = vb;  s2_if.tvldb  = vb;
      s_if.tlast  = l;   s2_if.tlast  = l;
      s_if.tuser  = u;   s2_if.tuser  = u;
   endtask

   task automatic idle();
      drive(1'b0, $urandom, 2'($urandom), 1'($urandom), 1'($urandom));
      @(posedge clk_i);
      #1;
   endtask

   task automatic beat(input logic [31:0] d, input logic [1:0] vb, input bit l, input bit u);
      drive(1'b1, d, vb, l, u);
      @(posedge clk_i);
      #1;
      drive(1'b0, $urandom, 2'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic wait_empty();
      int n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(posedge clk_i);
         n++;
      end
      @(posedge clk_i);
      #1;
      chk("drain_timeout", (n >= 3000) ? 1 : 0, 0);
      mdl_used = 0;
   endtask

   // Frame-level model: a frame is forwarded iff the receiver is synced,
   // it is not flagged bad and it fits in the buffer space known to be free.
   task automatic send_frame(input int len, input bit bad, input bit gaps, input bit pat);
      logic [34:0] fr[$];
      logic [31:0] d;
      logic [1:0]  vl;
      if (mdl_used != 0 && mdl_used + len > DEPTH) wait_empty();
      vl = pat ? 2'd3 : 2'($urandom);
      for (int i = 0; i < len; i++) begin
         if (gaps && ($urandom % 4 == 0)) begin
            for (int g = 0; g < int'($urandom_range(1, 2)); g++) idle();
         end
         d = pat ? {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} : $urandom;
         if (i == len - 1) begin
            beat(d, vl, 1'b1, bad);
            fr.push_back({1'b1, vl, d});
         end else begin
            beat(d, 2'($urandom), 1'b0, 1'($urandom));
            fr.push_back({1'b0, 2'd0, d});
         end
      end
      if (!mdl_sync) begin
         mdl_sync = 1'b1;
      end else if (bad || len > DEPTH) begin
         mdl_drop++;
      end else begin
         foreach (fr[j]) exp_q.push_back(fr[j]);
         mdl_good++;
         mdl_used += len;
      end
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      drive(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
      exp_q.delete();
      mdl_good = 0;
      mdl_drop = 0;
      mdl_sync = 1'b0;
      mdl_used = 0;
      #1;
      chk("rst_tvalid", int'(m_if.tvalid), 0);
      chk("rst_tdata",  int'(m_if.tdata),  0);
      chk("rst_tlast",  int'(m_if.tlast),  0);
      chk("rst_tvldb",  int'(m_if.tvldb),  0);
      chk_cnt("rst");
      repeat (3) @(posedge clk_i);
      #1;
      rst_n_i = 1'b1;
   endtask

   task automatic set_ready(input bit r);
      rdy_mode = 0;
      rdy_fix  = r;
      repeat (2) @(posedge clk_i);
      #1;
   endtask

   initial begin
      drive(1'b0, 32'd0, 2'd0, 1'b0, 1'b0);
      #2;
      do_reset();
      set_ready(1'b1);

      // Partial-frame sync: first tlast only aligns, nothing counted
      send_frame(1, 1'b0, 1'b0, 1'b1);
      chk_cnt("sync");

      // Single good frame and its latency
      send_frame(4, 1'b0, 1'b0, 1'b1);
      @(negedge clk_i); chk("lat_k",  int'(m_if.tvalid), 0);
      @(negedge clk_i); chk("lat_k1", int'(m_if.tvalid), 0);
      @(negedge clk_i); chk("lat_k2", int'(m_if.tvalid), 1);
      wait_empty();
      chk_cnt("single");

      // Bad frame between two good frames
      send_frame(3, 1'b0, 1'b0, 1'b0);
      send_frame(5, 1'b1, 1'b0, 1'b0);
      send_frame(2, 1'b0, 1'b0, 1'b0);
      wait_empty();
      chk_cnt("badmid");

      // Back-to-back frames stream without bubbles
      send_frame(4, 1'b0, 1'b0, 1'b0);
      send_frame(2, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk_i);
         chk("stream_valid", int'(m_if.tvalid), 1);
      end
      wait_empty();

      // Overflow with downstream stalled
      set_ready(1'b0);
      send_frame(20, 1'b0, 1'b0, 1'b0);
      repeat (4) @(negedge clk_i);
      chk("ovf_no_output", int'(m_if.tvalid), 0);
      chk_cnt("ovf");
      send_frame(4, 1'b0, 1'b0, 1'b0);
      chk_cnt("ovf_next");
      set_ready(1'b1);
      wait_empty();

      // Bad tlast arriving while full counts once; exact-fit frame commits
      set_ready(1'b0);
      send_frame(17, 1'b1, 1'b0, 1'b0);
      chk_cnt("full_bad");
      send_frame(16, 1'b0, 1'b0, 1'b0);
      chk_cnt("exact_fit");
      repeat (3) @(negedge clk_i);
      chk("fit_valid", int'(m_if.tvalid), 1);
      set_ready(1'b1);
      wait_empty();

      // Backpressure 1,0,0 pattern
      pat_cnt  = 0;
      rdy_mode = 2;
      send_frame(6, 1'b0, 1'b0, 1'b0);
      wait_empty();
      set_ready(1'b1);

      // Reset in the middle of a frame
      beat($urandom, 2'd0, 1'b0, 1'b0);
      beat($urandom, 2'd0, 1'b0, 1'b0);
      do_reset();
      send_frame(3, 1'b0, 1'b0, 1'b0);
      send_frame(2, 1'b0, 1'b0, 1'b0);
      wait_empty();
      chk_cnt("midrst");

      // Saturation of the narrow counters
      for (int i = 0; i < 5; i++) send_frame(2, 1'b0, 1'b0, 1'b0);
      wait_empty();
      chk_cnt("sat");
      chk("sat_good2", int'(good2), 3);

      // Randomized traffic with random backpressure
      rdy_mode = 1;
      for (int f = 0; f < 150; f++) begin
         send_frame(int'($urandom_range(1, 22)), ($urandom % 5 == 0),
                    ($urandom % 2 == 0), 1'b0);
         if (f % 30 == 29) chk_cnt("rand_mid");
      end
      wait_empty();
      chk_cnt("rand_end");
      set_ready(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
